// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array edge feeders.
// Imported by the feeder interface, the skew delay line and the feeder top.
package systolic_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int LANES_DEF      = 16;
    localparam int K_WIDTH_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

    // Counter width able to hold 0..n-2; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand-vector handshake between an upstream producer and the skew feeder.
// One full vector moves per beat (vec_valid & vec_ready).
interface systolic_skew_feeder_if
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LANES      = LANES_DEF
);

    logic [DATA_WIDTH-1:0] vec [LANES];
    logic                  vec_valid;
    logic                  vec_ready;

    modport master (
        output vec,
        output vec_valid,
        input  vec_ready
    );

    modport slave (
        input  vec,
        input  vec_valid,
        output vec_ready
    );

endinterface

// File: rtl/skew_delay_line.sv
// DEPTH-stage data+valid shift register used to skew one feeder lane.
// DEPTH=0 is a plain wire so lane 0 carries no extra latency.
module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic [DATA_WIDTH-1:0] dly_data,
    output logic                  dly_valid
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dly_data  = src_data;
            assign dly_valid = src_valid;
        end else begin : g_shift
            logic [DATA_WIDTH-1:0] data_r  [DEPTH];
            logic                  valid_r [DEPTH];

            // Shift data and valid one stage per clock; reset empties the line.
            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < DEPTH; s++) begin
                        data_r[s]  <= '0;
                        valid_r[s] <= 1'b0;
                    end
                end else begin
                    data_r[0]  <= src_data;
                    valid_r[0] <= src_valid;
                    for (int s = 1; s < DEPTH; s++) begin
                        data_r[s]  <= data_r[s-1];
                        valid_r[s] <= valid_r[s-1];
                    end
                end
            end

            assign dly_data  = data_r[DEPTH-1];
            assign dly_valid = valid_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// Accepts K operand vectors and emits them diagonally skewed (lane i delayed
// by i cycles) for the systolic PE grid, then drains and pulses done.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int K_WIDTH    = K_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [K_WIDTH-1:0]    k_len_i,
    systolic_skew_feeder_if.slave vec_if,
    output logic [DATA_WIDTH-1:0] lane_o       [LANES],
    output logic                  lane_valid_o [LANES],
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int                  DRAIN_W    = cnt_width(LANES);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'((LANES > 1) ? LANES - 2 : 0);
    localparam logic [DRAIN_W-1:0]  DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [K_WIDTH-1:0]  K_ONE      = K_WIDTH'(1);

    feeder_state_e         state_r;
    logic [K_WIDTH-1:0]    k_len_r;
    logic [K_WIDTH-1:0]    beat_cnt_r;
    logic [DRAIN_W-1:0]    drain_cnt_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  beat_s;
    logic                  last_beat_s;
    logic [DATA_WIDTH-1:0] head_data_r  [LANES];
    logic                  head_valid_r [LANES];

    assign beat_s      = vec_if.vec_valid & ready_r;
    // beat_cnt_r never exceeds k_len_r-1, so the increment cannot wrap.
    assign last_beat_s = beat_s & ((beat_cnt_r + K_ONE) == k_len_r);

    // Tile sequencer with registered ready/busy/done outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            k_len_r     <= '0;
            beat_cnt_r  <= '0;
            drain_cnt_r <= '0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        k_len_r     <= k_len_i;
                        beat_cnt_r  <= '0;
                        drain_cnt_r <= '0;
                        busy_r      <= 1'b1;
                        if (k_len_i == '0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= STREAM;
                            ready_r <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (beat_s) begin
                        beat_cnt_r <= beat_cnt_r + K_ONE;
                        if (last_beat_s) begin
                            ready_r <= 1'b0;
                            if (LANES == 1) begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // LANES-1 drain cycles let the last beat reach the final lane.
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Lane head registers: capture the accepted vector, zero-fill on bubbles.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                head_data_r[i]  <= '0;
                head_valid_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                head_valid_r[i] <= beat_s;
                head_data_r[i]  <= beat_s ? vec_if.vec[i] : '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            skew_delay_line #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (gi)
            ) u_skew (
                .clk_i     (clk_i),
                .rst_n     (rst_n),
                .src_data  (head_data_r[gi]),
                .src_valid (head_valid_r[gi]),
                .dly_data  (lane_o[gi]),
                .dly_valid (lane_valid_o[gi])
            );
        end
    endgenerate

    assign vec_if.vec_ready = ready_r;
    assign busy_o           = busy_r;
    assign done_o           = done_r;

endmodule
